uart_tx_framed: RTL

//   Configurable UART transmitter: successor to the fixed 8n1 transmitter. Buffers

---
 rtl/uart_tx_framed_pkg.sv | 30 +++
 rtl/uart_tx_framed_fifo_sync.sv | 59 +++++
 rtl/uart_tx_framed.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framed_pkg.sv
// Shared definitions for the framed UART transmitter: parity modes, FSM states,
// common baud divisors at 125 MHz and the parity helper.
package uart_tx_framed_pkg;

    localparam logic [1:0] UART_PAR_NONE = 2'b00;
    localparam logic [1:0] UART_PAR_EVEN = 2'b01;
    localparam logic [1:0] UART_PAR_ODD  = 2'b10;

    // Bit period minus one at 125 MHz (4M rounds 31.25 cycles down to 31)
    localparam int unsigned UART_DIV_115200_125M = 1084;
    localparam int unsigned UART_DIV_4M_125M     = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == UART_PAR_EVEN) || (mode == UART_PAR_ODD);
    endfunction

    // Word is zero-extended to 9 bits; the padding does not change the XOR
    function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] word);
        return (mode == UART_PAR_ODD) ? ~^word : ^word;
    endfunction

endpackage

// File: rtl/uart_tx_framed_fifo_sync.sv
// Single-clock FIFO with registered occupancy count; push into a full FIFO and
// pop from an empty one are ignored.
module uart_tx_framed_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: FIFO-fed, LSB-first frames with per-frame latched
// divisor, optional parity and one or two stop bits.
module uart_tx_framed
    import uart_tx_framed_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]        fifo_count;

    tx_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bit_end, load_frame;

    uart_tx_framed_fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid && ready),
        .din   (data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready = !fifo_full;
    assign busy  = (state_q != ST_IDLE) || (fifo_count != '0);
    assign tx    = tx_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        bit_end    = (timer_q == '0);

        case (state_q)
            ST_IDLE: begin
                load_frame = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    timer_d   = div_q;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = div_q;
                    if (bit_idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    timer_d    = div_q;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        timer_d    = div_q;
                    end else if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Popping a word also snapshots the line configuration for its whole frame
        if (load_frame) begin
            fifo_pop  = 1'b1;
            state_d   = ST_START;
            timer_d   = divisor;
            div_d     = divisor;
            shift_d   = fifo_dout;
            par_en_d  = parity_on(parity);
            par_bit_d = parity_bit(parity, 9'(fifo_dout));
            stop2_d   = stop2;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule
